// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register and its sequencer.
// Select codes, FSM states and command field values live here.
package usr_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  localparam logic MODE_TX = 1'b0;
  localparam logic MODE_RX = 1'b1;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } usr_state_e;

  function automatic logic [1:0] shift_sel(
    input logic dir
  );
    return (dir == DIR_L) ? SEL_SHL : SEL_SHR;
  endfunction

endpackage

// File: rtl/usr_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Existing block driven by usr_shift_ctrl; it has no reset of its own.
module usr_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] D,
  input  logic             data_in_sr,
  input  logic             data_in_sl,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] q
);

  // One operation per edge as chosen by sel.
  always_ff @(posedge clk) begin
    unique case (sel)
      SEL_HOLD: q <= q;
      SEL_SHR:  q <= {data_in_sr, q[WIDTH-1:1]};
      SEL_SHL:  q <= {q[WIDTH-2:0], data_in_sl};
      SEL_LOAD: q <= D;
      default:  q <= q;
    endcase
  end

endmodule

// File: rtl/usr_shift_ctrl.sv
// Command sequencer for the universal shift register.
// TX loads then shifts a word out; RX shifts WIDTH bits in.
module usr_shift_ctrl
  import usr_pkg::*;
#(
  parameter int   WIDTH = 4,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_sel,
  output logic [WIDTH-1:0] usr_d,
  output logic             usr_sr_in,
  output logic             usr_sl_in,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  usr_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;

  // State and captured command; reset leaves sel at hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_TX;
      dir_q   <= DIR_R;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
    end
  end

  // Next state and register controls, all decoded from state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    dir_d         = dir_q;
    data_d        = data_q;
    cmd_ready     = 1'b0;
    usr_sel       = SEL_HOLD;
    usr_d         = '0;
    usr_sr_in     = FILL;
    usr_sl_in     = FILL;
    ser_out_valid = 1'b0;
    rx_valid      = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          mode_d = cmd_mode;
          dir_d  = cmd_dir;
          data_d = cmd_data;
          cnt_d  = '0;
          if (cmd_mode == MODE_RX)
            state_d = SHIFT;
          else
            state_d = LOAD;
        end
      end
      LOAD: begin
        usr_sel = SEL_LOAD;
        usr_d   = data_q;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        usr_sel = shift_sel(dir_q);
        if (mode_q == MODE_TX) begin
          ser_out_valid = 1'b1;
        end else if (dir_q == DIR_L) begin
          usr_sl_in = ser_in;
        end else begin
          usr_sr_in = ser_in;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done     = 1'b1;
        rx_valid = (mode_q == MODE_RX);
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Serial tap follows the captured direction; qualify with valid.
  always_comb begin
    ser_out = (dir_q == DIR_L) ? usr_q[WIDTH-1] : usr_q[0];
    rx_data = usr_q;
  end

endmodule
